// File: rtl/writeback_arbiter.sv
// Merges single-cycle ALU results and FIFO-buffered memory results onto one register-file
// write port, with a per-register pending scoreboard. Optional forwarding: WB_BYPASS_EN.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [4:0]                  issue_reg,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_reg,
  input  logic [31:0]                 alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [4:0]                  mem_reg,
  input  logic [31:0]                 mem_data,
  output logic                        reg_write,
  output logic [4:0]                  reg_to_write,
  output logic [31:0]                 write_data,
  input  logic [4:0]                  query_reg_1,
  input  logic [4:0]                  query_reg_2,
  output logic                        busy_1,
  output logic                        busy_2,
`ifdef WB_BYPASS_EN
  output logic                        fwd_1,
  output logic                        fwd_2,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [REG_W-1:0]  fifo_reg  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              push;
  logic              pop;

  logic              sel_vld_p0;
  logic [REG_W-1:0]  sel_reg_p0;
  logic [DATA_W-1:0] sel_data_p0;

  logic [31:0]       pending;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;

  // Full blocks a push even when the head pops in the same cycle.
  assign empty      = (count == '0);
  assign mem_ready  = (count != FULL_CNT);
  assign push       = mem_valid && mem_ready;
  assign pop        = !alu_valid && !empty;
  assign fifo_count = count;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= mem_reg;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p0: fixed-priority selection, ALU over FIFO head
  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_reg_p0  = '0;
    sel_data_p0 = '0;
    if (alu_valid) begin
      sel_vld_p0  = 1'b1;
      sel_reg_p0  = alu_reg;
      sel_data_p0 = alu_data;
    end else if (!empty) begin
      sel_vld_p0  = 1'b1;
      sel_reg_p0  = fifo_reg[rd_ptr];
      sel_data_p0 = fifo_data[rd_ptr];
    end
  end

  // Stage p1: registered write port; register 0 is consumed without a strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write    <= 1'b0;
      reg_to_write <= '0;
      write_data   <= '0;
    end else begin
      reg_write <= sel_vld_p0 && (sel_reg_p0 != '0);
      if (sel_vld_p0) begin
        reg_to_write <= sel_reg_p0;
        write_data   <= sel_data_p0;
      end
    end
  end

  // Bit 0 never gets set, so a query of register 0 always reads idle.
  assign set_mask = (issue_valid && issue_reg != '0) ? (32'd1 << issue_reg) : '0;
  assign clr_mask = reg_write ? (32'd1 << reg_to_write) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_1  = reg_write && (reg_to_write == query_reg_1) && (query_reg_1 != '0);
  assign fwd_2  = reg_write && (reg_to_write == query_reg_2) && (query_reg_2 != '0);
  assign busy_1 = pending[query_reg_1] && !fwd_1;
  assign busy_2 = pending[query_reg_2] && !fwd_2;
`else
  assign busy_1 = pending[query_reg_1];
  assign busy_2 = pending[query_reg_2];
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: table of single-cycle vectors plus hand-written
// sequences for FIFO backpressure and asynchronous reset.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  reg_to_write;
  logic [31:0] write_data;
  logic [4:0]  query_reg_1;
  logic [4:0]  query_reg_2;
  logic        busy_1;
  logic        busy_2;
  logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
  logic        fwd_1;
  logic        fwd_2;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  writeback_arbiter #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .reg_write(reg_write), .reg_to_write(reg_to_write), .write_data(write_data),
    .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
    .busy_1(busy_1), .busy_2(busy_2),
`ifdef WB_BYPASS_EN
    .fwd_1(fwd_1), .fwd_2(fwd_2),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [4:0]  ir;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_rw;
    logic [4:0]  e_rtw;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    issue_valid = 1'b0; issue_reg = '0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    query_reg_1 = '0; query_reg_2 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        eb1;
    logic        eb2;
    int          mi;
    int          nwr;
    int          push5_cyc;
    logic        acc;
    logic [4:0]  wr_reg  [16];
    logic [31:0] wr_data [16];

    // rows: inputs for one cycle, then expected outputs after its rising edge
    tbl[0]  = '{1'b1,5'd5,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd5,5'd0, 1'b0,5'd0,32'h0,       1'b1,3'd0,1'b1,1'b0};
    tbl[1]  = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd5,5'd0, 1'b0,5'd0,32'h0,       1'b1,3'd0,1'b1,1'b0};
    tbl[2]  = '{1'b0,5'd0,1'b1,5'd5,32'hDEADBEEF,1'b0,5'd0,32'h0,  5'd5,5'd0, 1'b1,5'd5,32'hDEADBEEF,1'b1,3'd0,1'b1,1'b0};
    tbl[3]  = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd5,5'd0, 1'b0,5'd5,32'hDEADBEEF,1'b1,3'd0,1'b0,1'b0};
    tbl[4]  = '{1'b1,5'd7,1'b1,5'd8,32'h22,      1'b1,5'd7,32'h11, 5'd7,5'd8, 1'b1,5'd8,32'h22,      1'b1,3'd1,1'b1,1'b0};
    tbl[5]  = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd7,5'd8, 1'b1,5'd7,32'h11,      1'b1,3'd0,1'b1,1'b0};
    tbl[6]  = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd7,5'd8, 1'b0,5'd7,32'h11,      1'b1,3'd0,1'b0,1'b0};
    tbl[7]  = '{1'b0,5'd0,1'b1,5'd0,32'hFFFFFFFF,1'b0,5'd0,32'h0,  5'd0,5'd0, 1'b0,5'd0,32'hFFFFFFFF,1'b1,3'd0,1'b0,1'b0};
    tbl[8]  = '{1'b1,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd0,5'd0, 1'b0,5'd0,32'hFFFFFFFF,1'b1,3'd0,1'b0,1'b0};
    tbl[9]  = '{1'b1,5'd9,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd9,5'd0, 1'b0,5'd0,32'hFFFFFFFF,1'b1,3'd0,1'b1,1'b0};
    tbl[10] = '{1'b0,5'd0,1'b1,5'd9,32'h99,      1'b0,5'd0,32'h0,  5'd9,5'd0, 1'b1,5'd9,32'h99,      1'b1,3'd0,1'b1,1'b0};
    tbl[11] = '{1'b1,5'd9,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd9,5'd0, 1'b0,5'd9,32'h99,      1'b1,3'd0,1'b1,1'b0};
    tbl[12] = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd9,5'd0, 1'b0,5'd9,32'h99,      1'b1,3'd0,1'b1,1'b0};
    tbl[13] = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b1,5'd0,32'h55, 5'd9,5'd0, 1'b0,5'd9,32'h99,      1'b1,3'd1,1'b1,1'b0};
    tbl[14] = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd9,5'd0, 1'b0,5'd0,32'h55,      1'b1,3'd0,1'b1,1'b0};
    tbl[15] = '{1'b0,5'd0,1'b1,5'd9,32'hAB,      1'b0,5'd0,32'h0,  5'd9,5'd0, 1'b1,5'd9,32'hAB,      1'b1,3'd0,1'b1,1'b0};
    tbl[16] = '{1'b0,5'd0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,  5'd9,5'd0, 1'b0,5'd9,32'hAB,      1'b1,3'd0,1'b0,1'b0};

    reset = 1'b1;
    set_idle();
    @(posedge clock); @(posedge clock); #1;
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_reg_to_write", 32'(reg_to_write), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_busy_1", 32'(busy_1), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      issue_valid = tbl[i].iv; issue_reg = tbl[i].ir;
      alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_reg = tbl[i].mr; mem_data = tbl[i].md;
      query_reg_1 = tbl[i].q1; query_reg_2 = tbl[i].q2;
      @(posedge clock); #1;
      eb1 = tbl[i].e_b1;
      eb2 = tbl[i].e_b2;
`ifdef WB_BYPASS_EN
      if (tbl[i].e_rw && tbl[i].e_rtw == tbl[i].q1 && tbl[i].q1 != 5'd0) eb1 = 1'b0;
      if (tbl[i].e_rw && tbl[i].e_rtw == tbl[i].q2 && tbl[i].q2 != 5'd0) eb2 = 1'b0;
      chk($sformatf("row%0d_fwd_1", i), 32'(fwd_1), 32'(tbl[i].e_rw && tbl[i].e_rtw == tbl[i].q1 && tbl[i].q1 != 5'd0));
`endif
      chk($sformatf("row%0d_reg_write", i), 32'(reg_write), 32'(tbl[i].e_rw));
      chk($sformatf("row%0d_reg_to_write", i), 32'(reg_to_write), 32'(tbl[i].e_rtw));
      chk($sformatf("row%0d_write_data", i), write_data, tbl[i].e_wd);
      chk($sformatf("row%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d_busy_1", i), 32'(busy_1), 32'(eb1));
      chk($sformatf("row%0d_busy_2", i), 32'(busy_2), 32'(eb2));
    end

    set_idle();
    @(posedge clock); #1;

    // ALU busy for 6 cycles while 5 memory results arrive; FIFO fills, then drains in order
    mi = 0; nwr = 0; push5_cyc = -1;
    for (int c = 0; c < 30; c++) begin
      alu_valid = (c < 6); alu_reg = 5'(20 + c); alu_data = 32'hA000 + 32'(c);
      mem_valid = (mi < 5); mem_reg = 5'(10 + mi); mem_data = 32'hB000 + 32'(mi);
      #1;
      acc = mem_valid && mem_ready;
      @(posedge clock); #1;
      if (acc) begin
        mi++;
        if (mi == 5) push5_cyc = c;
        if (mi == 4) begin
          chk("full_mem_ready", 32'(mem_ready), 32'd0);
          chk("full_fifo_count", 32'(fifo_count), 32'd4);
        end
      end
      if (reg_write && nwr < 16) begin
        wr_reg[nwr] = reg_to_write;
        wr_data[nwr] = write_data;
        nwr++;
      end
    end
    chk("drain_write_count", 32'(nwr), 32'd11);
    chk("fifth_push_cycle", 32'(push5_cyc), 32'd7);
    chk("drain_fifo_count", 32'(fifo_count), 32'd0);
    for (int i = 0; i < nwr && i < 11; i++) begin
      chk($sformatf("drain%0d_reg", i), 32'(wr_reg[i]), (i < 6) ? 32'(20 + i) : 32'(4 + i));
      chk($sformatf("drain%0d_data", i), wr_data[i], (i < 6) ? 32'hA000 + 32'(i) : 32'hB000 + 32'(i - 6));
    end

    // Asynchronous reset with 3 FIFO entries, 2 pending bits and a live write strobe
    set_idle();
    @(posedge clock); #1;
    issue_valid = 1'b1; issue_reg = 5'd3;
    alu_valid = 1'b1; alu_reg = 5'd30; alu_data = 32'h1;
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'hC0;
    @(posedge clock); #1;
    issue_reg = 5'd4; mem_reg = 5'd4; mem_data = 32'hC1;
    @(posedge clock); #1;
    issue_valid = 1'b0; mem_reg = 5'd5; mem_data = 32'hC2;
    @(posedge clock); #1;
    mem_valid = 1'b0;
    query_reg_1 = 5'd3; query_reg_2 = 5'd4;
    #1;
    chk("pre_reg_write", 32'(reg_write), 32'd1);
    chk("pre_fifo_count", 32'(fifo_count), 32'd3);
    chk("pre_busy_1", 32'(busy_1), 32'd1);
    chk("pre_busy_2", 32'(busy_2), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_reg_write", 32'(reg_write), 32'd0);
    chk("arst_fifo_count", 32'(fifo_count), 32'd0);
    chk("arst_mem_ready", 32'(mem_ready), 32'd1);
    chk("arst_busy_1", 32'(busy_1), 32'd0);
    chk("arst_busy_2", 32'(busy_2), 32'd0);
    chk("arst_write_data", write_data, 32'd0);
    alu_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      chk($sformatf("post_rst%0d_reg_write", c), 32'(reg_write), 32'd0);
    end
    chk("post_rst_fifo_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
